// File: rtl/sop_sweep_checker_if.sv
// sop_sweep_checker_if: the write, control and result bus of sop_sweep_checker.
// The master drives the mask/cube writes and start; the slave returns the sweep results.
interface sop_sweep_checker_if #(parameter int N = 4, parameter int K = 4);
    localparam int IW = K > 1 ? $clog2(K) : 1;
    logic              mask_we;
    logic [(1<<N)-1:0] mask_in;
    logic              cube_we;
    logic [IW-1:0]     cube_idx;
    logic              cube_en;
    logic [N-1:0]      cube_care;
    logic [N-1:0]      cube_val;
    logic              start;
    logic              busy;
    logic              done;
    logic [N-1:0]      x_out;
    logic              s1;
    logic              s2;
    logic [N:0]        mismatch_cnt;
    logic [N-1:0]      first_fail;
    logic              first_fail_vld;
    modport master(output mask_we, mask_in, cube_we, cube_idx, cube_en, cube_care, cube_val, start,
                   input busy, done, x_out, s1, s2, mismatch_cnt, first_fail, first_fail_vld);
    modport slave(input mask_we, mask_in, cube_we, cube_idx, cube_en, cube_care, cube_val, start,
                  output busy, done, x_out, s1, s2, mismatch_cnt, first_fail, first_fail_vld);
endinterface

// File: rtl/sop_sweep_checker.sv
// sop_sweep_checker: sweeps every input vector, comparing a canonical SoP (minterm mask) with a cube cover.
// Define SOP_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module sop_sweep_checker #(
    parameter int N = 4,
    parameter int K = 4
) (
    input logic clk,
    input logic rst,
    sop_sweep_checker_if.slave bus
);
    localparam int M = 1 << N;
    localparam logic [1:0] IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [M-1:0] mask_q, mask_d;
    logic [K-1:0] en_q, en_d;
    logic [N-1:0] care_q [K];
    logic [N-1:0] care_d [K];
    logic [N-1:0] val_q [K];
    logic [N-1:0] val_d [K];
    logic [N-1:0] cnt_q, cnt_d, x_q, x_d, ff_q, ff_d;
    logic [N:0]   mc_q, mc_d;
    logic         s1_q, s1_d, s2_q, s2_d, ffv_q, ffv_d;
    logic         hit, fail, last;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < K; i++)
            hit = hit | (en_q[i] && ((cnt_q ^ val_q[i]) & care_q[i]) == '0);
        fail = mask_q[cnt_q] != hit;
        last = &cnt_q;
        mask_d = mask_q;
        en_d = en_q;
        care_d = care_q;
        val_d = val_q;
        // Configuration is only writable while idle so a sweep sees a stable function.
        if (state_q == IDLE && bus.mask_we) mask_d = bus.mask_in;
        if (state_q == IDLE && bus.cube_we) begin
            en_d[bus.cube_idx] = bus.cube_en;
            care_d[bus.cube_idx] = bus.cube_care;
            val_d[bus.cube_idx] = bus.cube_val;
        end
        state_d = state_q;
        cnt_d = cnt_q;
        x_d = x_q;
        s1_d = s1_q;
        s2_d = s2_q;
        mc_d = mc_q;
        ff_d = ff_q;
        ffv_d = ffv_q;
        if (state_q == IDLE && bus.start) begin
            state_d = SWEEP;
            cnt_d = '0;
            mc_d = '0;
            ff_d = '0;
            ffv_d = 1'b0;
        end else if (state_q == SWEEP) begin
            x_d = cnt_q;
            s1_d = mask_q[cnt_q];
            s2_d = hit;
            cnt_d = last ? cnt_q : cnt_q + 1'b1;
            if (fail) begin
                mc_d = mc_q + 1'b1;
                ff_d = ffv_q ? ff_q : cnt_q;
                ffv_d = 1'b1;
            end
`ifdef SOP_SWEEP_STOP_ON_FAIL_EN
            state_d = (last || fail) ? DONE : SWEEP;
`else
            state_d = last ? DONE : SWEEP;
`endif
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q <= '0;
            en_q <= '0;
            care_q <= '{default: '0};
            val_q <= '{default: '0};
            cnt_q <= '0;
            x_q <= '0;
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            mc_q <= '0;
            ff_q <= '0;
            ffv_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q <= mask_d;
            en_q <= en_d;
            care_q <= care_d;
            val_q <= val_d;
            cnt_q <= cnt_d;
            x_q <= x_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            mc_q <= mc_d;
            ff_q <= ff_d;
            ffv_q <= ffv_d;
        end
    end

    assign bus.busy = state_q == SWEEP;
    assign bus.done = state_q == DONE;
    assign bus.x_out = x_q;
    assign bus.s1 = s1_q;
    assign bus.s2 = s2_q;
    assign bus.mismatch_cnt = mc_q;
    assign bus.first_fail = ff_q;
    assign bus.first_fail_vld = ffv_q;
endmodule

// File: tb/tb_sop_sweep_checker.sv
// tb_sop_sweep_checker: directed and random sweeps; expected per-vector results come from a
// truth-table model of the mask and cube list, queued at start and popped by a separate monitor.
module tb_sop_sweep_checker;
    localparam int N = 4, K = 4, M = 16;
`ifdef SOP_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0, total = 0, bad = 0, t0;

    sop_sweep_checker_if #(.N(N), .K(K)) bus();
    sop_sweep_checker #(.N(N), .K(K)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [N-1:0] x; logic s1, s2, busy; logic [N:0] mc;} vexp_t;
    typedef struct {int dcyc; logic [N:0] mc; logic [N-1:0] ff; logic ffv;} sexp_t;
    vexp_t vq[$];
    sexp_t sq[$];
    vexp_t e;
    sexp_t s;
    logic mon_pb;

    logic [M-1:0] m_mask;
    logic         m_en [K];
    logic [N-1:0] m_care [K];
    logic [N-1:0] m_val [K];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Truth table of both forms, vector by vector, straight from the function definition.
    task automatic model_push(input int start_cyc);
        logic [N:0] mc;
        logic [N-1:0] ff;
        logic ffv, a, b, ok;
        int nvec;
        vexp_t ve;
        sexp_t se;
        mc = '0; ff = '0; ffv = 1'b0; nvec = M;
        for (int v = 0; v < M; v++) begin
            a = m_mask[v];
            b = 1'b0;
            for (int k = 0; k < K; k++) begin
                ok = m_en[k];
                for (int j = 0; j < N; j++)
                    if (m_care[k][j] && (v[j] != m_val[k][j])) ok = 1'b0;
                b = b | ok;
            end
            if (a != b) begin
                mc++;
                if (!ffv) begin ff = N'(v); ffv = 1'b1; end
            end
            ve.x = N'(v); ve.s1 = a; ve.s2 = b; ve.busy = 1'b1; ve.mc = mc;
            vq.push_back(ve);
            if (STOP && a != b) begin nvec = v + 1; break; end
        end
        vq[vq.size()-1].busy = 1'b0;
        se.dcyc = start_cyc + 1 + nvec; se.mc = mc; se.ff = ff; se.ffv = ffv;
        sq.push_back(se);
    endtask

    task automatic wr(input logic mw, input logic [M-1:0] m, input logic cw, input int idx,
                      input logic en, input logic [N-1:0] c, input logic [N-1:0] v, input bit upd);
        @(negedge clk);
        bus.mask_we = mw; bus.mask_in = m; bus.cube_we = cw; bus.cube_idx = 2'(idx);
        bus.cube_en = en; bus.cube_care = c; bus.cube_val = v;
        if (upd && mw) m_mask = m;
        if (upd && cw) begin m_en[idx] = en; m_care[idx] = c; m_val[idx] = v; end
        @(negedge clk);
        bus.mask_we = 1'b0; bus.cube_we = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && !bus.done; i++) @(negedge clk);
        chk("done_seen", bus.done, 1);
    endtask

    task automatic begin_sweep();
        @(negedge clk);
        bus.start = 1'b1; t0 = cyc; model_push(t0);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic sweep();
        begin_sweep();
        wait_done();
    endtask

    task automatic zero_check(input string nm);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_done"}, bus.done, 0);
        chk({nm, "_x"}, bus.x_out, 0);
        chk({nm, "_s1"}, bus.s1, 0);
        chk({nm, "_s2"}, bus.s2, 0);
        chk({nm, "_cnt"}, bus.mismatch_cnt, 0);
        chk({nm, "_ff"}, bus.first_fail, 0);
        chk({nm, "_vld"}, bus.first_fail_vld, 0);
    endtask

    task automatic clear_shadow();
        m_mask = '0;
        for (int k = 0; k < K; k++) begin m_en[k] = 1'b0; m_care[k] = '0; m_val[k] = '0; end
    endtask

    // Monitor: every edge taken in SWEEP yields one vector; a done pulse closes the sweep.
    initial begin
        mon_pb = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) mon_pb = 1'b0;
            else begin
                if (mon_pb) begin
                    chk("vec_expected", vq.size() > 0, 1);
                    if (vq.size() > 0) begin
                        e = vq.pop_front();
                        chk("x_out", bus.x_out, e.x);
                        chk("s1", bus.s1, e.s1);
                        chk("s2", bus.s2, e.s2);
                        chk("busy", bus.busy, e.busy);
                        chk("run_cnt", bus.mismatch_cnt, e.mc);
                    end
                end
                if (bus.done) begin
                    chk("done_expected", sq.size() > 0, 1);
                    if (sq.size() > 0) begin
                        s = sq.pop_front();
                        chk("done_cycle", cyc, s.dcyc);
                        chk("fin_cnt", bus.mismatch_cnt, s.mc);
                        chk("fin_ff", bus.first_fail, s.ff);
                        chk("fin_vld", bus.first_fail_vld, s.ffv);
                    end
                end
                mon_pb = bus.busy;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.mask_we = 1'b0; bus.mask_in = '0; bus.cube_we = 1'b0; bus.cube_idx = '0;
        bus.cube_en = 1'b0; bus.cube_care = '0; bus.cube_val = '0; bus.start = 1'b0;
        clear_shadow();
        repeat (2) @(negedge clk);
        zero_check("reset");
        rst = 1'b0;

        // Reference cover: exactly matches mask 0x232B.
        wr(1'b1, 16'h232B, 1'b1, 0, 1'b1, 4'b0011, 4'b0001, 1'b1);
        wr(1'b0, '0, 1'b1, 1, 1'b1, 4'b0111, 4'b0000, 1'b1);
        wr(1'b0, '0, 1'b1, 2, 1'b1, 4'b1101, 4'b0001, 1'b1);
        sweep();
        chk("exact_cnt", bus.mismatch_cnt, 0);
        chk("exact_vld", bus.first_fail_vld, 0);

        // Writes and a second start while sweeping, and writes during done, are all ignored.
        begin_sweep();
        repeat (3) @(negedge clk);
        bus.mask_we = 1'b1; bus.mask_in = '1; bus.start = 1'b1;
        bus.cube_we = 1'b1; bus.cube_idx = 2'd3; bus.cube_en = 1'b1; bus.cube_care = '0;
        @(negedge clk);
        bus.mask_we = 1'b0; bus.start = 1'b0; bus.cube_we = 1'b0;
        wait_done();
        bus.mask_we = 1'b1; bus.mask_in = '1; bus.cube_we = 1'b1;
        @(negedge clk);
        bus.mask_we = 1'b0; bus.cube_we = 1'b0;
        sweep();
        chk("ignored_cnt", bus.mismatch_cnt, 0);

        // Reset in the middle of a sweep: immediate clear, no done, mask and cubes gone.
        begin_sweep();
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1 zero_check("midrst");
        vq.delete(); sq.delete(); clear_shadow();
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (20) @(negedge clk);
        sweep();
        chk("postrst_cnt", bus.mismatch_cnt, 0);

        // Slot 1 disabled, written in the same cycle as the mask.
        wr(1'b1, 16'h232B, 1'b1, 0, 1'b1, 4'b0011, 4'b0001, 1'b1);
        wr(1'b1, 16'h232B, 1'b1, 1, 1'b0, 4'b0111, 4'b0000, 1'b1);
        wr(1'b0, '0, 1'b1, 2, 1'b1, 4'b1101, 4'b0001, 1'b1);
        sweep();
        chk("miss_cnt", bus.mismatch_cnt, STOP ? 1 : 2);
        chk("miss_ff", bus.first_fail, 0);
        chk("miss_vld", bus.first_fail_vld, 1);

        // Tautology cube against all-ones and all-zeros masks.
        wr(1'b1, 16'hFFFF, 1'b1, 0, 1'b1, 4'b0000, 4'b0000, 1'b1);
        wr(1'b0, '0, 1'b1, 2, 1'b0, 4'b0000, 4'b0000, 1'b1);
        sweep();
        chk("taut_cnt", bus.mismatch_cnt, 0);
        wr(1'b1, 16'h0000, 1'b0, 0, 1'b0, 4'b0000, 4'b0000, 1'b1);
        sweep();
        chk("taut_full_cnt", bus.mismatch_cnt, STOP ? 1 : 16);

        for (int r = 0; r < 12; r++) begin
            wr(1'b1, 16'($urandom), 1'b1, 0, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'b1);
            for (int k = 1; k < K; k++)
                wr(1'b0, '0, 1'b1, k, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'b1);
            sweep();
        end

        repeat (3) @(negedge clk);
        chk("queues_drained", vq.size() + sq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sop_sweep_checker.md
SOP_SWEEP_CHECKER -- requirements
Module: sop_sweep_checker

Interface
REQ-001 Parameter N, default 4: number of function inputs; variable order x_out[N-1] (MSB) .. x_out[0] (LSB).
REQ-002 Parameter K, default 4: number of implicant cube slots in the simplified cover.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 mask_we  input  1  write strobe for the minterm mask.
REQ-006 mask_in  input  2^N  minterm mask; bit m=1 means minterm m is in the canonical SoP.
REQ-007 cube_we  input  1  write strobe for one cube slot.
REQ-008 cube_idx  input  clog2(K)  cube slot written.
REQ-009 cube_en  input  1  slot enable value written.
REQ-010 cube_care  input  N  care bits; 0 = literal absent from the cube.
REQ-011 cube_val  input  N  literal polarity for cared bits.
REQ-012 start  input  1  one-cycle request to begin a sweep.
REQ-013 busy  output  1  high while sweeping.
REQ-014 done  output  1  one-cycle pulse at sweep end.
REQ-015 x_out  output  N  vector evaluated in the previous cycle (registered).
REQ-016 s1  output  1  registered canonical SoP result for x_out.
REQ-017 s2  output  1  registered simplified-cover result for x_out.
REQ-018 mismatch_cnt  output  N+1  number of vectors with s1 != s2 in the current or last sweep.
REQ-019 first_fail  output  N  lowest vector with a mismatch; first_fail_vld  output  1  marks it valid.

Function
REQ-020 s1 SHALL equal mask_reg[v]; s2 SHALL be the OR over enabled slots of ((v XOR val) AND care) == 0.
REQ-021 An enabled cube with care = 0 SHALL match every vector; if no slot is enabled, s2 SHALL be 0.
REQ-022 FSM states SHALL be IDLE, SWEEP and DONE, with IDLE as the reset state.
REQ-023 IDLE + start: go to SWEEP and clear mismatch_cnt, first_fail and first_fail_vld on that edge; the vector counter starts at 0.
REQ-024 In SWEEP, one vector per cycle (0, 1, .. 2^N-1): x_out, s1 and s2 SHALL update on the edge that evaluates the vector, and mismatch_cnt/first_fail SHALL update on the same edge.
REQ-025 After vector 2^N-1, the FSM SHALL enter DONE; done=1 for exactly that one cycle, then return to IDLE; start-to-done latency SHALL be 2^N+1 cycles.
REQ-026 The vector counter SHALL NOT wrap within a sweep; mismatch_cnt SHALL reach 2^N without overflow.
REQ-027 busy SHALL be 1 in SWEEP only.
REQ-028 start SHALL be ignored in SWEEP and DONE.
REQ-029 mask_we and cube_we SHALL take effect in IDLE only and SHALL be ignored while busy or in DONE.
REQ-030 If mask_we and cube_we are both asserted, both writes SHALL occur.
REQ-031 Results SHALL hold in IDLE until the next start.

Reset
REQ-032 rst SHALL immediately set: state IDLE; busy, done, s1, s2 = 0; x_out = 0; mismatch_cnt = 0; first_fail = 0; first_fail_vld = 0; mask_reg = 0; all cube_en = 0, care = 0, val = 0.
REQ-033 rst asserted mid-sweep SHALL abort the sweep with no done pulse.

Configuration
REQ-034 When SOP_SWEEP_STOP_ON_FAIL_EN is defined, the first mismatch SHALL move SWEEP to DONE on the next edge, leaving mismatch_cnt = 1 and first_fail = the failing vector.
REQ-035 When SOP_SWEEP_STOP_ON_FAIL_EN is undefined, every sweep SHALL cover all 2^N vectors.

Verification
REQ-036 N=4, mask 0x232B, cubes {care 0011/val 0001, 0111/0000, 1101/0001} enabled, start -> done at cycle 17, mismatch_cnt=0, first_fail_vld=0.
REQ-037 Same setup with slot 1 disabled -> mismatch_cnt=2, first_fail=0000, first_fail_vld=1.
REQ-038 Same as REQ-037 with SOP_SWEEP_STOP_ON_FAIL_EN defined -> done 2 cycles after start, mismatch_cnt=1, first_fail=0000.
REQ-039 Assert rst at sweep cycle 5 -> all outputs 0 immediately, no done pulse, mask_reg reads back 0 (next sweep gives s1=0 everywhere).
REQ-040 mask_we with 0xFFFF during a sweep, then a second start -> results unchanged from the first sweep (write ignored, start ignored while busy).
REQ-041 Single enabled cube with care=0000, mask 0xFFFF -> mismatch_cnt=0; mask 0x0000 -> mismatch_cnt=16 (10000b).
